// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the two datapath requesters, the arbiter and data_mem.
// The arbiter takes the slave view; requesters plus memory take the master view.
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_r_w;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, rdata0, rdata1, busy, mem_addr, mem_wdata, mem_r_w
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, rdata0, rdata1, busy, mem_addr, mem_wdata, mem_r_w
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter that serialises single-word requests from two ports
// onto the shared data_mem port, one transaction every three cycles.
module data_mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  data_mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              sel_q;
  logic              we_q;
  logic              lastGrant_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic              loadReq;
  logic              winnerSel;
  logic              captureRd;
  logic              retireTx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // On a tie the port that did not win last time is chosen.
  always_comb begin
    state_d      = state_q;
    loadReq      = 1'b0;
    winnerSel    = 1'b0;
    captureRd    = 1'b0;
    retireTx     = 1'b0;
    bus.ack0     = 1'b0;
    bus.ack1     = 1'b0;
    bus.busy     = 1'b0;
    bus.mem_r_w  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          loadReq   = 1'b1;
          winnerSel = bus.req1 & (~bus.req0 | ~lastGrant_q);
          state_d   = GRANT;
        end
      end
      GRANT: begin
        bus.busy    = 1'b1;
        bus.mem_r_w = we_q;
        captureRd   = ~we_q;
        state_d     = DONE;
      end
      DONE: begin
        bus.busy = 1'b1;
        bus.ack0 = ~sel_q;
        bus.ack1 = sel_q;
        retireTx = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Latched copies let requesters change their inputs right after selection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lastGrant_q <= 1'b1;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      if (loadReq) begin
        sel_q   <= winnerSel;
        we_q    <= winnerSel ? bus.we1    : bus.we0;
        addr_q  <= winnerSel ? bus.addr1  : bus.addr0;
        wdata_q <= winnerSel ? bus.wdata1 : bus.wdata0;
      end
      if (captureRd) begin
        if (sel_q) begin
          rdata1_q <= bus.mem_rdata;
        end else begin
          rdata0_q <= bus.mem_rdata;
        end
      end
      if (retireTx) begin
        lastGrant_q <= sel_q;
      end
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: a transaction-level model predicts every
// output each cycle, and literal expectations pin key results of each scenario.
module tb_data_mem_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  data_mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  data_mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int errors   = 0;
  int cycleCnt = 0;
  int rwCount  = 0;
  int ackPort[$];
  int ackCyc[$];

  // Memory contents start as addr ^ 0x5A so reads of untouched words are distinctive.
  logic [7:0] envMem [256];
  bit         envInit = 1'b0;

  assign bus.mem_rdata = envMem[bus.mem_addr];

  always @(posedge clk) begin
    if (!envInit) begin
      for (int i = 0; i < 256; i++) envMem[i] <= 8'(i) ^ 8'h5A;
      envInit <= 1'b1;
    end else if (bus.mem_r_w) begin
      envMem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  always @(posedge clk) cycleCnt++;

  always @(negedge clk) begin
    if (bus.mem_r_w) rwCount++;
    if (bus.ack0) begin
      ackPort.push_back(0);
      ackCyc.push_back(cycleCnt);
    end
    if (bus.ack1) begin
      ackPort.push_back(1);
      ackCyc.push_back(cycleCnt);
    end
  end

  // Transaction model: a selection at edge k drives memory during k..k+1,
  // acks during k+1..k+2, and the next selection can happen at edge k+3.
  logic [7:0] modelMem [256];
  bit         modelInit = 1'b0;
  bit         mActive, mSel, mWe, mLastG;
  int         mEdge, mK, mFreeFrom;
  logic [7:0] mAddr, mWdata;
  logic       expAck0, expAck1, expBusy, expRw;
  logic [7:0] expAddr, expWdata, expRdata0, expRdata1;

  always @(posedge clk or negedge rst_n) begin
    if (!modelInit) begin
      for (int i = 0; i < 256; i++) modelMem[i] = 8'(i) ^ 8'h5A;
      modelInit = 1'b1;
    end
    if (!rst_n) begin
      mActive = 1'b0; mSel = 1'b0; mWe = 1'b0; mLastG = 1'b1;
      mEdge = 0; mK = 0; mFreeFrom = 0;
      mAddr = 8'h00; mWdata = 8'h00;
      expAck0 = 1'b0; expAck1 = 1'b0; expBusy = 1'b0; expRw = 1'b0;
      expAddr = 8'h00; expWdata = 8'h00; expRdata0 = 8'h00; expRdata1 = 8'h00;
    end else begin
      mEdge++;
      if (mActive && mEdge == mK + 1) begin
        if (mWe) modelMem[mAddr] = mWdata;
        else if (mSel) expRdata1 = modelMem[mAddr];
        else expRdata0 = modelMem[mAddr];
      end
      if (mActive && mEdge == mK + 2) begin
        mLastG  = mSel;
        mActive = 1'b0;
      end
      if (!mActive && mEdge >= mFreeFrom && (bus.req0 || bus.req1)) begin
        mSel      = (bus.req0 && bus.req1) ? !mLastG : bus.req1;
        mWe       = mSel ? bus.we1 : bus.we0;
        mAddr     = mSel ? bus.addr1 : bus.addr0;
        mWdata    = mSel ? bus.wdata1 : bus.wdata0;
        mK        = mEdge;
        mActive   = 1'b1;
        mFreeFrom = mEdge + 3;
      end
      expBusy  = mActive;
      expRw    = mActive && (mEdge == mK) && mWe;
      expAck0  = mActive && (mEdge == mK + 1) && !mSel;
      expAck1  = mActive && (mEdge == mK + 1) && mSel;
      expAddr  = mAddr;
      expWdata = mWdata;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h time=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic failNote(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s timed out waiting for ack time=%0t", name, $time);
  endtask

  always @(negedge clk) begin
    checkOutput("ack0",      32'(bus.ack0),      32'(expAck0));
    checkOutput("ack1",      32'(bus.ack1),      32'(expAck1));
    checkOutput("busy",      32'(bus.busy),      32'(expBusy));
    checkOutput("mem_r_w",   32'(bus.mem_r_w),   32'(expRw));
    checkOutput("mem_addr",  32'(bus.mem_addr),  32'(expAddr));
    checkOutput("mem_wdata", 32'(bus.mem_wdata), 32'(expWdata));
    checkOutput("rdata0",    32'(bus.rdata0),    32'(expRdata0));
    checkOutput("rdata1",    32'(bus.rdata1),    32'(expRdata1));
  end

  task automatic applyStimulus(input int port, input logic we, input logic [7:0] addr,
                               input logic [7:0] wdata, output logic [7:0] rd);
    bit got = 1'b0;
    rd = 8'h00;
    @(posedge clk); #1;
    if (port == 0) begin
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
    end else begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if ((port == 0) ? bus.ack0 : bus.ack1) begin
        rd  = (port == 0) ? bus.rdata0 : bus.rdata1;
        got = 1'b1;
        break;
      end
    end
    if (!got) failNote("stimulus_ack");
    if (port == 0) bus.req0 = 1'b0;
    else bus.req1 = 1'b0;
  endtask

  task automatic waitAcks(input int n);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk); #1;
      if (ackPort.size() >= n) return;
    end
    failNote("wait_acks");
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clearLog();
    ackPort.delete();
    ackCyc.delete();
  endtask

  logic [7:0] rd, rdA, rdB;
  int         sampleCyc, ackAt, rwBase;
  bit         got;

  initial begin
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h30; bus.wdata0 = 8'h00;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = 8'h00; bus.wdata1 = 8'h00;

    // Reset held with a pending request: nothing may happen.
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_ack0",   32'(bus.ack0),    32'h0);
    checkOutput("rst_busy",   32'(bus.busy),    32'h0);
    checkOutput("rst_rw",     32'(bus.mem_r_w), 32'h0);
    checkOutput("rst_rdata0", 32'(bus.rdata0),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    sampleCyc = cycleCnt;
    got = 1'b0;
    ackAt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (bus.ack0) begin
        ackAt = cycleCnt;
        got = 1'b1;
        break;
      end
    end
    if (!got) failNote("rst_first_ack");
    else checkOutput("rst_ack_latency", 32'(ackAt - sampleCyc), 32'd1);
    checkOutput("rst_first_rdata0", 32'(bus.rdata0), 32'h6A);
    bus.req0 = 1'b0;

    // Port 0 writes two words then reads them back.
    rwBase = rwCount;
    applyStimulus(0, 1'b1, 8'h00, 8'h01, rd);
    applyStimulus(0, 1'b1, 8'h01, 8'h07, rd);
    checkOutput("write_rw_cycles", 32'(rwCount - rwBase), 32'd2);
    applyStimulus(0, 1'b0, 8'h00, 8'h00, rd);
    checkOutput("read_addr0", 32'(rd), 32'h01);
    applyStimulus(0, 1'b0, 8'h01, 8'h00, rd);
    checkOutput("read_addr1", 32'(rd), 32'h07);

    // Tie right after reset: port 0 first, so port 1's data survives.
    applyReset();
    clearLog();
    fork
      applyStimulus(0, 1'b1, 8'h10, 8'hAA, rdA);
      applyStimulus(1, 1'b1, 8'h10, 8'h55, rdB);
    join
    if (ackPort.size() < 2) failNote("tie_acks");
    else begin
      checkOutput("tie_first",  32'(ackPort[0]), 32'd0);
      checkOutput("tie_second", 32'(ackPort[1]), 32'd1);
    end
    applyStimulus(1, 1'b0, 8'h10, 8'h00, rd);
    checkOutput("tie_readback", 32'(rd), 32'h55);

    // Continuous contention: strict alternation, one ack every 3 cycles.
    repeat (2) @(posedge clk);
    clearLog();
    @(posedge clk); #1;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h00;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'hFF;
    waitAcks(6);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    if (ackPort.size() < 6) failNote("contention_acks");
    else begin
      for (int i = 0; i < 6; i++) begin
        checkOutput($sformatf("contention_port%0d", i), 32'(ackPort[i]), 32'(i % 2));
        if (i > 0) checkOutput($sformatf("contention_gap%0d", i), 32'(ackCyc[i] - ackCyc[i-1]), 32'd3);
      end
    end
    checkOutput("contention_rdata1", 32'(bus.rdata1), 32'hA5);
    checkOutput("contention_rdata0", 32'(bus.rdata0), 32'h01);

    // Reset during GRANT of a write: no write, no ack.
    repeat (3) @(posedge clk);
    clearLog();
    #1;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h20; bus.wdata0 = 8'h3C;
    @(posedge clk); #2;
    checkOutput("abort_grant_rw", 32'(bus.mem_r_w), 32'h1);
    rst_n = 1'b0;
    bus.req0 = 1'b0;
    #1;
    checkOutput("abort_rw_drop", 32'(bus.mem_r_w), 32'h0);
    checkOutput("abort_busy",    32'(bus.busy),    32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    checkOutput("abort_no_ack", 32'(ackPort.size()), 32'd0);
    applyStimulus(0, 1'b0, 8'h20, 8'h00, rd);
    checkOutput("abort_old_value", 32'(rd), 32'h7A);

    // Held request: the second ack follows 3 cycles after the first.
    clearLog();
    @(posedge clk); #1;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h05;
    waitAcks(2);
    bus.req1 = 1'b0;
    if (ackPort.size() < 2) failNote("held_acks");
    else begin
      checkOutput("held_port_a", 32'(ackPort[0]), 32'd1);
      checkOutput("held_port_b", 32'(ackPort[1]), 32'd1);
      checkOutput("held_gap",    32'(ackCyc[1] - ackCyc[0]), 32'd3);
    end
    checkOutput("held_rdata1", 32'(bus.rdata1), 32'h5F);

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
